// File: rtl/overlay_ram_arbiter_pkg.sv
// Shared register-map constants and state typedefs for the overlay RAM arbiter.
// Optional clear engine is selected with the OVERLAY_CLEAR_EN macro.
package overlay_ram_arbiter_pkg;

    localparam logic [31:0] BASE_OVERLAY_RAM   = 32'h2000_0000;
    localparam logic [31:0] OVL_CTRL_ADDR      = 32'h3000_0000;
    localparam int unsigned CTRL_CLR_START_BIT = 0;
    localparam int unsigned CTRL_ERR_BIT       = 1;

    typedef enum logic [1:0] {
        B_IDLE,
        B_PEND,
        B_RD
    } bus_state_e;

    typedef enum logic {
        C_IDLE,
        C_RUN
    } clr_state_e;

    // Upper 12 address bits select the 1 MiB overlay RAM window.
    function automatic logic is_ram_hit(input logic [31:0] addr);
        return {addr[31:20], 20'h0} == BASE_OVERLAY_RAM;
    endfunction

endpackage

// File: rtl/overlay_ram_arbiter_clear_seq.sv
// Clear sequencer: walks every RAM word writing zero, only in cycles the arbiter marks free.
// Built only when OVERLAY_CLEAR_EN is defined.
module overlay_clear_seq
    import overlay_ram_arbiter_pkg::*;
#(
    parameter int unsigned AW = 13
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          free_i,
    output logic          busy_o,
    output logic          we_o,
    output logic [AW-1:0] addr_o
);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    // Next state: start is ignored while running; counter advances only on free cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            C_IDLE: begin
                if (start_i) begin
                    state_d = C_RUN;
                    cnt_d   = '0;
                end
            end
            C_RUN: begin
                if (free_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_d = C_IDLE;
                    end
                end
            end
            default: state_d = C_IDLE;
        endcase
    end

    // State and word counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= C_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o = (state_q == C_RUN);
    assign we_o   = busy_o;
    assign addr_o = cnt_q;

endmodule

// File: rtl/overlay_ram_arbiter.sv
// Single-port overlay RAM arbiter: display fetch (priority) > CPU bus > optional clear engine.
// Optional clear engine is selected with the OVERLAY_CLEAR_EN macro.
module overlay_ram_arbiter
    import overlay_ram_arbiter_pkg::*;
#(
    parameter int unsigned AW = 13,
    parameter int unsigned DW = 32
) (
    input  logic          clk_50mhz,
    input  logic          rst,
    input  logic [31:0]   bus_addr,
    input  logic [31:0]   bus_wdata,
    input  logic          bus_ren,
    input  logic          bus_wen,
    output logic [31:0]   bus_rdata,
    output logic          bus_rvalid,
    output logic          bus_busy,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic [DW-1:0] disp_rdata,
    output logic          disp_valid,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    bus_state_e    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic          disp_pipe_q, disp_pipe_d;
    logic          disp_valid_q, disp_valid_d;
    logic [DW-1:0] disp_rdata_q, disp_rdata_d;

    logic          strobe, ram_hit, ctrl_hit, busy, grant, ctrl_rd, ctrl_wr;
    logic          clr_busy, clr_we;
    logic [AW-1:0] clr_addr;

    assign strobe   = bus_ren | bus_wen;
    assign ram_hit  = is_ram_hit(bus_addr);
    assign ctrl_hit = (bus_addr == OVL_CTRL_ADDR);
    assign busy     = (state_q != B_IDLE);
    assign grant    = (state_q == B_PEND) && !disp_req;
    assign ctrl_rd  = strobe && !busy && ctrl_hit && !bus_wen;
    assign ctrl_wr  = strobe && !busy && ctrl_hit && bus_wen;

`ifdef OVERLAY_CLEAR_EN
    logic clr_free;
    assign clr_free = !disp_req && !grant;

    overlay_clear_seq #(
        .AW(AW)
    ) u_clear_seq (
        .clk_i  (clk_50mhz),
        .rst_i  (rst),
        .start_i(ctrl_wr && bus_wdata[CTRL_CLR_START_BIT]),
        .free_i (clr_free),
        .busy_o (clr_busy),
        .we_o   (clr_we),
        .addr_o (clr_addr)
    );
`else
    assign clr_busy = 1'b0;
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    // RAM port mux; display is routed combinationally so its fetch is never delayed.
    always_comb begin
        ram_addr = addr_q;
        ram_we   = 1'b0;
        ram_din  = wdata_q;
        if (disp_req) begin
            ram_addr = disp_addr;
        end else if (grant) begin
            ram_we = we_q;
        end else if (clr_we) begin
            ram_addr = clr_addr;
            ram_we   = 1'b1;
            ram_din  = '0;
        end
    end

    // Bus FSM next state, CTRL register access and read-return data.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        case (state_q)
            B_IDLE: begin
                if (strobe && ram_hit) begin
                    state_d = B_PEND;
                    addr_d  = bus_addr[AW+1:2];
                    wdata_d = bus_wdata;
                    we_d    = bus_wen;
                end else if (ctrl_rd) begin
                    rvalid_d = 1'b1;
                    rdata_d  = {30'b0, err_q, clr_busy};
                end else if (ctrl_wr && bus_wdata[CTRL_ERR_BIT]) begin
                    err_d = 1'b0;
                end
            end
            B_PEND: begin
                if (!disp_req) begin
                    state_d = we_q ? B_IDLE : B_RD;
                end
            end
            B_RD: begin
                state_d  = B_IDLE;
                rdata_d  = ram_dout;
                rvalid_d = 1'b1;
            end
            default: state_d = B_IDLE;
        endcase
        if (strobe && busy) begin
            err_d = 1'b1;
        end
    end

    // Display return pipeline: RAM data arrives one cycle after the request, then is registered.
    always_comb begin
        disp_pipe_d  = disp_req;
        disp_valid_d = disp_pipe_q;
        disp_rdata_d = disp_pipe_q ? ram_dout : disp_rdata_q;
    end

    // All arbiter state registers.
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            state_q      <= B_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            disp_pipe_q  <= 1'b0;
            disp_valid_q <= 1'b0;
            disp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
            disp_pipe_q  <= disp_pipe_d;
            disp_valid_q <= disp_valid_d;
            disp_rdata_q <= disp_rdata_d;
        end
    end

    assign bus_rdata  = rdata_q;
    assign bus_rvalid = rvalid_q;
    assign bus_busy   = busy;
    assign disp_rdata = disp_rdata_q;
    assign disp_valid = disp_valid_q;

endmodule

// File: tb/tb_overlay_ram_arbiter.sv
// Bench for overlay_ram_arbiter: directed timing cases plus randomized traffic against a
// cycle-level reference model. Clear-engine checks are compiled in with OVERLAY_CLEAR_EN.
module tb_overlay_ram_arbiter;
    import overlay_ram_arbiter_pkg::*;

    localparam int AW    = 13;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk_50mhz = 1'b0;
    logic          rst;
    logic [31:0]   bus_addr, bus_wdata, bus_rdata;
    logic          bus_ren, bus_wen, bus_rvalid, bus_busy;
    logic          disp_req, disp_valid, ram_we;
    logic [AW-1:0] disp_addr, ram_addr;
    logic [DW-1:0] disp_rdata, ram_din, ram_dout;

    logic [DW-1:0] mem [0:DEPTH-1];
    logic [31:0]   ref_mem [0:15];
    int            checks = 0;
    int            passes = 0;
    int            cyc = 0;

    overlay_ram_arbiter #(
        .AW(AW),
        .DW(DW)
    ) dut (
        .clk_50mhz (clk_50mhz),
        .rst       (rst),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ren   (bus_ren),
        .bus_wen   (bus_wen),
        .bus_rdata (bus_rdata),
        .bus_rvalid(bus_rvalid),
        .bus_busy  (bus_busy),
        .disp_req  (disp_req),
        .disp_addr (disp_addr),
        .disp_rdata(disp_rdata),
        .disp_valid(disp_valid),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    // Single-port synchronous RAM model.
    always @(posedge clk_50mhz) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_50mhz);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] baddr(input int w);
        return BASE_OVERLAY_RAM + 32'(w) * 4;
    endfunction

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus_addr = a; bus_wdata = d; bus_wen = 1'b1;
        tick();
        bus_wen = 1'b0;
        tick();
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output int lat);
        bus_addr = a; bus_ren = 1'b1;
        tick();
        bus_ren = 1'b0;
        lat = 1;
        while (!bus_rvalid && lat < 40) begin
            tick();
            lat++;
        end
        d = bus_rdata;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdata"}, bus_rdata, 32'h0);
        check({tag, "_rvalid"}, 32'(bus_rvalid), 32'h0);
        check({tag, "_busy"}, 32'(bus_busy), 32'h0);
        check({tag, "_disp_rdata"}, disp_rdata, 32'h0);
        check({tag, "_disp_valid"}, 32'(disp_valid), 32'h0);
        check({tag, "_ram_we"}, 32'(ram_we), 32'h0);
        check({tag, "_ram_addr"}, 32'(ram_addr), 32'h0);
    endtask

    initial begin
        logic [31:0] d, v7, x11;
        int          lat;
        // Reference model state for randomized traffic.
        logic        pend, pend_we, dreq, exp_busy, exp_dv, do_strobe;
        logic [3:0]  pend_w, da;
        logic [31:0] pend_d, ret_data;
        int          ret_cyc, run;
        int          dq_cyc[$];
        logic [31:0] dq_dat[$];

        rst = 1'b1; bus_addr = '0; bus_wdata = '0; bus_ren = 1'b0; bus_wen = 1'b0;
        disp_req = 1'b0; disp_addr = '0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Uncontended write then read of word 5.
        bus_addr = baddr(5); bus_wdata = 32'hDEADBEEF; bus_wen = 1'b1;
        tick();
        bus_wen = 1'b0;
        check("wr_busy", 32'(bus_busy), 32'h1);
        check("wr_grant_we", 32'(ram_we), 32'h1);
        check("wr_grant_addr", 32'(ram_addr), 32'd5);
        check("wr_grant_din", ram_din, 32'hDEADBEEF);
        tick();
        check("wr_done_busy", 32'(bus_busy), 32'h0);
        ref_mem[5] = 32'hDEADBEEF;
        bus_read(baddr(5), d, lat);
        check("rd5_latency", 32'(lat), 32'd3);
        check("rd5_data", d, 32'hDEADBEEF);

        // Read and write strobes together behave as a write.
        bus_addr = baddr(6); bus_wdata = 32'hA5A50006; bus_ren = 1'b1; bus_wen = 1'b1;
        tick();
        bus_ren = 1'b0; bus_wen = 1'b0;
        tick();
        ref_mem[6] = 32'hA5A50006;
        bus_read(baddr(6), d, lat);
        check("rw_both_data", d, 32'hA5A50006);

        // Display fetch returns exactly two cycles after the request.
        bus_write(baddr(9), 32'h12345678);
        ref_mem[9] = 32'h12345678;
        disp_req = 1'b1; disp_addr = 13'd9;
        tick();
        disp_req = 1'b0;
        check("disp_not_early", 32'(disp_valid), 32'h0);
        tick();
        check("disp_valid", 32'(disp_valid), 32'h1);
        check("disp_data", disp_rdata, 32'h12345678);
        tick();
        check("disp_pulse", 32'(disp_valid), 32'h0);

        // Bus read of word 7 starved by display on N+1..N+3.
        v7 = $urandom;
        bus_write(baddr(7), v7);
        ref_mem[7] = v7;
        bus_addr = baddr(7); bus_ren = 1'b1;
        tick();
        bus_ren = 1'b0; disp_req = 1'b1; disp_addr = 13'd9;
        #1;
        check("cont_disp_addr", 32'(ram_addr), 32'd9);
        check("cont_disp_we", 32'(ram_we), 32'h0);
        tick();
        tick();
        check("cont_dv1", 32'(disp_valid), 32'h1);
        check("cont_dd1", disp_rdata, 32'h12345678);
        tick();
        disp_req = 1'b0;
        #1;
        check("cont_grant_addr", 32'(ram_addr), 32'd7);
        check("cont_busy", 32'(bus_busy), 32'h1);
        check("cont_dv2", 32'(disp_valid), 32'h1);
        tick();
        check("cont_dv3", 32'(disp_valid), 32'h1);
        check("cont_rvalid_early", 32'(bus_rvalid), 32'h0);
        tick();
        check("cont_rvalid", 32'(bus_rvalid), 32'h1);
        check("cont_rdata", bus_rdata, v7);

        // Strobe while busy is dropped and sets the sticky error bit.
        bus_write(baddr(12), 32'h0C0C0C0C);
        ref_mem[12] = 32'h0C0C0C0C;
        x11 = $urandom;
        bus_addr = baddr(11); bus_wdata = x11; bus_wen = 1'b1;
        tick();
        bus_addr = baddr(12); bus_wdata = 32'h00000BAD;
        tick();
        bus_wen = 1'b0;
        tick();
        ref_mem[11] = x11;
        bus_read(baddr(12), d, lat);
        check("drop_not_committed", d, 32'h0C0C0C0C);
        bus_read(baddr(11), d, lat);
        check("drop_first_kept", d, x11);
        bus_read(OVL_CTRL_ADDR, d, lat);
        check("ctrl_latency", 32'(lat), 32'd1);
        check("ctrl_err_set", d, 32'h2);
        bus_addr = OVL_CTRL_ADDR; bus_wdata = 32'h2; bus_wen = 1'b1;
        tick();
        bus_wen = 1'b0;
        bus_read(OVL_CTRL_ADDR, d, lat);
        check("ctrl_err_clr", d, 32'h0);

        // Randomized traffic against the reference model.
        for (int w = 0; w < 16; w++) begin
            ref_mem[w] = $urandom;
            bus_write(baddr(w), ref_mem[w]);
        end
        pend = 1'b0; pend_we = 1'b0; pend_w = '0; pend_d = '0;
        ret_cyc = -1; ret_data = '0; run = 0;
        for (int k = 0; k < 600; k++) begin
            exp_busy = pend || (cyc < ret_cyc);
            check("rnd_busy", 32'(bus_busy), 32'(exp_busy));
            check("rnd_rvalid", 32'(bus_rvalid), 32'(cyc == ret_cyc));
            if (cyc == ret_cyc) check("rnd_rdata", bus_rdata, ret_data);
            exp_dv = (dq_cyc.size() > 0) && (dq_cyc[0] == cyc);
            check("rnd_disp_valid", 32'(disp_valid), 32'(exp_dv));
            if (exp_dv) begin
                check("rnd_disp_data", disp_rdata, dq_dat[0]);
                void'(dq_cyc.pop_front());
                void'(dq_dat.pop_front());
            end
            bus_ren = 1'b0; bus_wen = 1'b0;
            dreq = (run < 3) && (k < 590) && ($urandom_range(0, 1) == 1);
            da = 4'($urandom_range(0, 15));
            run = dreq ? run + 1 : 0;
            disp_req = dreq; disp_addr = 13'(da);
            if (dreq) begin
                dq_cyc.push_back(cyc + 2);
                dq_dat.push_back(ref_mem[da]);
            end else if (pend) begin
                if (pend_we) ref_mem[pend_w] = pend_d;
                else begin
                    ret_cyc = cyc + 2;
                    ret_data = ref_mem[pend_w];
                end
                pend = 1'b0;
            end
            do_strobe = !exp_busy && (k < 585) && ($urandom_range(0, 2) == 0);
            if (do_strobe) begin
                pend = 1'b1;
                pend_we = 1'($urandom_range(0, 1));
                pend_w = 4'($urandom_range(0, 15));
                pend_d = $urandom;
                bus_addr = baddr(int'(pend_w)); bus_wdata = pend_d;
                bus_wen = pend_we; bus_ren = !pend_we;
            end
            tick();
        end
        bus_ren = 1'b0; bus_wen = 1'b0; disp_req = 1'b0;
        check("rnd_drained", 32'(dq_cyc.size()), 32'd0);
        tick();
        tick();

        // Reset while a write to word 3 is held pending by display traffic.
        disp_req = 1'b1; disp_addr = '0;
        bus_addr = baddr(3); bus_wdata = ~ref_mem[3]; bus_wen = 1'b1;
        tick();
        bus_wen = 1'b0;
        tick();
        check("rst_pend_busy", 32'(bus_busy), 32'h1);
        rst = 1'b1; disp_req = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick();
        rst = 1'b0;
        tick();
        bus_read(baddr(3), d, lat);
        check("midrst_word3", d, ref_mem[3]);

`ifdef OVERLAY_CLEAR_EN
        begin
            int nz, ctrl_ret, polls;
            logic done;
            for (int w = 0; w < DEPTH; w++) bus_write(baddr(w), 32'hFFFFFFFF);
            bus_addr = OVL_CTRL_ADDR; bus_wdata = 32'h1; bus_wen = 1'b1;
            tick();
            bus_wen = 1'b0;
            bus_read(OVL_CTRL_ADDR, d, lat);
            check("clr_running", d, 32'h1);
            dq_cyc.delete(); dq_dat.delete();
            run = 0; ctrl_ret = -1; done = 1'b0; polls = 0;
            while (!done && polls < 40000) begin
                polls++;
                exp_dv = (dq_cyc.size() > 0) && (dq_cyc[0] == cyc);
                check("clr_disp_valid", 32'(disp_valid), 32'(exp_dv));
                if (exp_dv) begin
                    check("clr_disp_data_ok",
                          32'((disp_rdata == 32'h0) || (disp_rdata == 32'hFFFFFFFF)), 32'h1);
                    void'(dq_cyc.pop_front());
                    void'(dq_dat.pop_front());
                end
                if (cyc == ctrl_ret && bus_rvalid && !bus_rdata[0]) done = 1'b1;
                bus_ren = 1'b0;
                dreq = (run < 3) && ($urandom_range(0, 1) == 1);
                run = dreq ? run + 1 : 0;
                disp_req = dreq; disp_addr = 13'($urandom_range(0, DEPTH - 1));
                if (dreq) begin
                    dq_cyc.push_back(cyc + 2);
                    dq_dat.push_back(32'h0);
                end
                if ((polls % 32) == 0) begin
                    bus_addr = OVL_CTRL_ADDR; bus_ren = 1'b1; ctrl_ret = cyc + 1;
                end
                tick();
            end
            bus_ren = 1'b0; disp_req = 1'b0;
            check("clr_finished", 32'(done), 32'h1);
            tick();
            tick();
            tick();
            nz = 0;
            for (int w = 0; w < DEPTH; w++) if (mem[w] !== 32'h0) nz++;
            check("clr_all_zero", 32'(nz), 32'd0);
            bus_read(baddr(DEPTH - 1), d, lat);
            check("clr_last_word", d, 32'h0);
            bus_read(OVL_CTRL_ADDR, d, lat);
            check("clr_idle", d, 32'h0);
        end
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
